uart_word_feeder: RTL
=====================

// Module: uart_word_feeder
// PURPOSE
//  Upstream stage of the 32-bit UART serializer. Buffers 32-bit sensor words in a small
//  synchronous FIFO. Hands them one at a time to the serializer via a trans_ack pulse /
//  done handshake, with a programmable idle gap between words.
//  Runs entirely in the send_clk (baud) domain. Provides fill, error and sent-count status.
// PARAMETERS
//  DEPTH        8   FIFO entries; power of two, >=2
//  GAP_CYCLES   2   idle send_clk cycles after done before next word is loaded; 0 = none
//  TIMEOUT      63  max cycles in WAIT before abort; must exceed one frame (~40 cycles)
// PORTS
//  send_clk     in   1              baud clock, all logic on posedge
//  rst          in   1              synchronous, active-low reset
//  wr_en        in   1              push wr_data into FIFO this cycle
//  wr_data      in   32             sensor word to send
//  full         out  1              FIFO full (registered from count)
//  fifo_level   out  $clog2(DEPTH)+1  current FIFO occupancy
//  tx_data      out  32             word presented to serializer data input
//  trans_ack    out  1              one-cycle start request to serializer
//  tx_done      in   1              serializer done flag (level, high while serializer is in end state)
//  busy         out  1              feeder not in S_IDLE
//  overflow     out  1              sticky: a write arrived while full
//  timeout_err  out  1              sticky: WAIT exceeded TIMEOUT
//  words_sent   out  16             count of completed words, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst==0 at posedge): FIFO emptied; state S_IDLE; outputs full=0, fifo_level=0,
//   tx_data=0, trans_ack=0, busy=0, overflow=0, timeout_err=0, words_sent=0.
//  FIFO: write when wr_en && !full. Write while full is dropped, and overflow<=1, even if
//   a pop occurs in the same cycle. Pop and write in the same cycle keep the level.
//   Pointers wrap modulo DEPTH.
//  FSM (all registered):
//   S_IDLE: !empty -> S_LOAD.
//   S_LOAD: pop head into tx_data -> S_REQ.
//   S_REQ: trans_ack=1 for exactly this cycle. tx_data holds until the next S_LOAD, because
//    the serializer samples it one cycle after trans_ack. Clear seen_low, tmo_cnt -> S_WAIT.
//   S_WAIT: seen_low<=1 when tx_done==0. Completion = tx_done==1 && seen_low, so a stale
//    done from the previous frame is ignored. On completion: words_sent++ ->
//    S_GAP (GAP_CYCLES>0) or S_IDLE. tmo_cnt increments per cycle; at tmo_cnt==TIMEOUT:
//    timeout_err<=1 -> S_IDLE, the word is lost and not counted.
//   S_GAP: counts GAP_CYCLES cycles -> S_IDLE.
//  trans_ack is decoded from state==S_REQ and is never high in two consecutive cycles.
//  Latency: wr_en in cycle 0 with empty FIFO and S_IDLE -> fifo_level=1 in cycle 1,
//   S_LOAD in cycle 2, trans_ack and new tx_data in cycle 3.
//  busy = (state != S_IDLE). Sticky flags clear only on reset.
//  Reset mid-frame: all state dropped immediately. The serializer shares rst, so no
//   partial handshake survives.
// STRUCTURE
//  Package uart_feeder_pkg: feeder_state_e {S_IDLE,S_LOAD,S_REQ,S_WAIT,S_GAP},
//   WORD_W=32, CNT_W=16.
//  Sub-module sync_fifo #(WIDTH,DEPTH) with wr_en/rd_en/dout/full/empty/level ports.
//   Top holds the FSM, gap/timeout counters, status regs.
// TESTING
//  1 Push 0xAABBCCDD into idle block, model serializer done ~40 cycles later ->
//    trans_ack at cycle 3, tx_data=0xAABBCCDD held until done, words_sent=1.
//  2 Push 3 words back-to-back -> three trans_ack pulses, each >= GAP_CYCLES+2 cycles after
//    the prior done, words sent in FIFO order.
//  3 Push 9 words with DEPTH=8 while the first is sending -> exactly the 9th dropped,
//    overflow=1, full=1 until first pop.
//  4 Hold tx_done=1 before and through S_REQ (stale done) -> no completion until done goes
//    0 then 1.
//  5 Never assert tx_done -> timeout_err=1 after 63 cycles in S_WAIT; FSM returns to S_IDLE
//    and the next word is sent.
//  6 Drop rst mid-S_WAIT with 4 queued -> next cycle fifo_level=0, trans_ack=0, busy=0,
//    counters and flags 0.

Source files
------------

// File: rtl/uart_feeder_pkg.sv
// Shared definitions for the UART word feeder.
// Contents:
//   WORD_W         width of a sensor word handed to the serializer
//   CNT_W          width of the completed-word counter
//   feeder_state_e handshake FSM states
package uart_feeder_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_GAP
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used to buffer sensor words ahead of the serializer.
// The head entry is always visible on dout_o, and a pop advances to the next entry.
// Ports:
//   send_clk   clock, all logic on posedge
//   rst        synchronous, active-low reset (empties the FIFO)
//   wr_en_i    push wr_data_i; ignored while full
//   wr_data_i  data to push
//   rd_en_i    pop the head entry; ignored while empty
//   dout_o     current head entry
//   full_o     registered full flag
//   empty_o    no entries held
//   level_o    current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     send_clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             full_q;
  logic             push;
  logic             pop;

  // Writes are qualified by the registered full flag, so a write that lands while
  // full is dropped even if a pop frees a slot in the same cycle.
  assign push = wr_en_i && !full_q;
  assign pop  = rd_en_i && (level_q != '0);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge send_clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
    end
  end

  // Storage needs no reset; resetting the pointers is enough to empty the FIFO.
  always_ff @(posedge send_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/uart_word_feeder.sv
// Upstream stage of the 32-bit UART serializer. Buffers sensor words in a FIFO and
// hands them one at a time to the serializer with a trans_ack pulse, waiting for the
// serializer's done level before the next word, with an idle gap in between.
// Ports:
//   send_clk      baud clock, all logic on posedge
//   rst           synchronous, active-low reset
//   wr_en_i       push wr_data_i into the FIFO
//   wr_data_i     sensor word to send
//   full_o        FIFO full
//   fifo_level_o  FIFO occupancy
//   tx_data_o     word presented to the serializer (held until the next load)
//   trans_ack_o   one-cycle start request to the serializer
//   tx_done_i     serializer done level
//   busy_o        feeder is not idle
//   overflow_o    sticky: a write arrived while full
//   timeout_err_o sticky: the serializer never completed a word
//   words_sent_o  completed word count, wraps
module uart_word_feeder
  import uart_feeder_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 63
) (
  input  logic                   send_clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [WORD_W-1:0]      wr_data_i,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic [WORD_W-1:0]      tx_data_o,
  output logic                   trans_ack_o,
  input  logic                   tx_done_i,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic                   timeout_err_o,
  output logic [CNT_W-1:0]       words_sent_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  feeder_state_e state_q;
  feeder_state_e state_d;

  logic [WORD_W-1:0] tx_data_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              seen_low_q;
  logic              overflow_q;
  logic              timeout_err_q;
  logic [CNT_W-1:0]  words_sent_q;

  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rd;
  logic              trans_ack;
  logic              busy;
  logic              done_ok;
  logic              tmo_hit;
  logic              gap_last;

  sync_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .send_clk (send_clk),
    .rst      (rst),
    .wr_en_i  (wr_en_i),
    .wr_data_i(wr_data_i),
    .rd_en_i  (fifo_rd),
    .dout_o   (fifo_dout),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (fifo_level_o)
  );

  // Done only counts after the serializer has been seen low in this frame, so a done
  // level left over from the previous frame cannot complete the new word.
  assign done_ok  = tx_done_i && seen_low_q;
  assign tmo_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT));
  assign gap_last = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge send_clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_LOAD;
      S_LOAD: state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (done_ok)      state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_GAP:  if (gap_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    trans_ack = (state_q == S_REQ);
    busy      = (state_q != S_IDLE);
    fifo_rd   = (state_q == S_LOAD);
  end

  // tx_data is loaded only in S_LOAD and otherwise held, because the serializer
  // samples it one cycle after trans_ack.
  always_ff @(posedge send_clk) begin
    if (!rst) begin
      tx_data_q     <= '0;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      seen_low_q    <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      words_sent_q  <= '0;
    end else begin
      if (wr_en_i && fifo_full) overflow_q <= 1'b1;
      case (state_q)
        S_LOAD: tx_data_q <= fifo_dout;
        S_REQ: begin
          seen_low_q <= 1'b0;
          tmo_cnt_q  <= '0;
        end
        S_WAIT: begin
          if (!tx_done_i) seen_low_q <= 1'b1;
          if (!tmo_hit)   tmo_cnt_q  <= tmo_cnt_q + TMO_W'(1);
          gap_cnt_q <= '0;
          if (done_ok)      words_sent_q  <= words_sent_q + CNT_W'(1);
          else if (tmo_hit) timeout_err_q <= 1'b1;
        end
        S_GAP: gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        default: begin
        end
      endcase
    end
  end

  assign full_o        = fifo_full;
  assign tx_data_o     = tx_data_q;
  assign trans_ack_o   = trans_ack;
  assign busy_o        = busy;
  assign overflow_o    = overflow_q;
  assign timeout_err_o = timeout_err_q;
  assign words_sent_o  = words_sent_q;

endmodule
